psx_poll_scheduler: RTL and testbench

PSX_POLL_SCHEDULER -- requirements
Module: psx_poll_scheduler

---
 rtl/psx_poll_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_psx_poll_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_poll_scheduler.sv
// PlayStation pad poll scheduler: walks the enabled ports, runs a 5-byte poll
// on a shared serial engine, validates the reply and latches button state.
module psx_poll_scheduler #(
    parameter int unsigned ATT_SETUP = 50,
    parameter int unsigned ATT_HOLD  = 50,
    parameter int unsigned TIMEOUT   = 4095,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_tick,
    input  logic [1:0]  port_en,
    output logic        eng_start,
    output logic [3:0]  eng_bytes,
    input  logic        eng_ready,
    input  logic        eng_err,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  cmd_byte,
    output logic [1:0]  att_n,
    output logic [15:0] pad0_buttons,
    output logic [15:0] pad1_buttons,
    output logic [1:0]  pad_valid,
    output logic        busy
);

    localparam int unsigned DLY_MAX = (ATT_SETUP > ATT_HOLD) ? ATT_SETUP : ATT_HOLD;
    localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TMO_W   = 12;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_START, S_WAIT, S_CHECK, S_FAIL, S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic               port_q, port_d;
    logic               pend_q, pend_d;
    logic               redo_q, redo_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   rty_q, rty_d;
    logic [4:1][7:0]    rx_q, rx_d;
    logic [15:0]        btn0_q, btn0_d, btn1_q, btn1_d;
    logic [1:0]         valid_q, valid_d;
    logic [1:0]         att_q, att_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        pend_d  = pend_q;
        redo_d  = redo_q;
        dly_d   = dly_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        rty_d   = rty_q;
        rx_d    = rx_q;
        btn0_d  = btn0_q;
        btn1_d  = btn1_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    dly_d  = '0;
                    if (port_en[0]) begin
                        port_d  = 1'b0;
                        state_d = S_SEL;
                    end else if (port_en[1]) begin
                        port_d  = 1'b1;
                        state_d = S_SEL;
                    end
                end
            end
            S_SEL: begin
                if (dly_q == DLY_W'(ATT_SETUP - 1)) begin
                    state_d = S_START;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_START: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rx_valid && (cnt_q < CNT_W'(5))) begin
                    case (cnt_q)
                        CNT_W'(1): rx_d[1] = rx_byte;
                        CNT_W'(2): rx_d[2] = rx_byte;
                        CNT_W'(3): rx_d[3] = rx_byte;
                        CNT_W'(4): rx_d[4] = rx_byte;
                        default:   ;
                    endcase
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Error beats a simultaneous ready
                if (eng_err) begin
                    state_d = S_FAIL;
                end else if (eng_ready) begin
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_FAIL;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CHECK: begin
                if ((cnt_q == CNT_W'(5)) && (rx_q[1] == 8'h41) && (rx_q[2] == 8'h5A)) begin
                    if (port_q) begin
                        btn1_d = ~{rx_q[4], rx_q[3]};
                    end else begin
                        btn0_d = ~{rx_q[4], rx_q[3]};
                    end
                    valid_d[port_q] = 1'b1;
                    rty_d   = '0;
                    redo_d  = 1'b0;
                    dly_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (rty_q < RTY_W'(MAX_RETRY)) begin
                    rty_d  = rty_q + RTY_W'(1);
                    redo_d = 1'b1;
                end else begin
                    valid_d[port_q] = 1'b0;
                    rty_d  = '0;
                    redo_d = 1'b0;
                end
                dly_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (dly_q == DLY_W'(ATT_HOLD - 1)) begin
                    dly_d  = '0;
                    redo_d = 1'b0;
                    if (redo_q) begin
                        state_d = S_SEL;
                    end else if (!port_q && port_en[1]) begin
                        port_d  = 1'b1;
                        state_d = S_SEL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A tick always lands in the single pending slot; repeats collapse
        if (poll_tick) begin
            pend_d = 1'b1;
        end

        att_d = 2'b11;
        if (state_d inside {S_SEL, S_START, S_WAIT, S_CHECK, S_FAIL}) begin
            att_d[port_d] = 1'b0;
        end
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            port_q  <= 1'b0;
            pend_q  <= 1'b0;
            redo_q  <= 1'b0;
            dly_q   <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            rty_q   <= '0;
            rx_q    <= '0;
            btn0_q  <= '0;
            btn1_q  <= '0;
            valid_q <= '0;
            att_q   <= 2'b11;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            pend_q  <= pend_d;
            redo_q  <= redo_d;
            dly_q   <= dly_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            rty_q   <= rty_d;
            rx_q    <= rx_d;
            btn0_q  <= btn0_d;
            btn1_q  <= btn1_d;
            valid_q <= valid_d;
            att_q   <= att_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    // Command byte tracks the byte counter directly
    always_comb begin
        case (cnt_q)
            CNT_W'(0): cmd_byte = 8'h01;
            CNT_W'(1): cmd_byte = 8'h42;
            default:   cmd_byte = 8'h00;
        endcase
    end

    assign eng_bytes    = 4'd5;
    assign eng_start    = start_q;
    assign att_n        = att_q;
    assign busy         = busy_q;
    assign pad_valid    = valid_q;
    assign pad0_buttons = btn0_q;
    assign pad1_buttons = btn1_q;

endmodule

// File: tb/tb_psx_poll_scheduler.sv
// Bench for psx_poll_scheduler: scripted pad-engine responder, table rows,
// corner sequences and random rounds against a per-round outcome model.
module tb_psx_poll_scheduler;

    localparam int ATT_SETUP = 50;
    localparam int ATT_HOLD  = 50;
    localparam int TIMEOUT   = 4095;
    localparam int MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        poll_tick = 1'b0;
    logic [1:0]  port_en = 2'b00;
    logic        eng_ready = 1'b0;
    logic        eng_err = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        eng_start;
    logic [3:0]  eng_bytes;
    logic [7:0]  cmd_byte;
    logic [1:0]  att_n;
    logic [15:0] pad0_buttons;
    logic [15:0] pad1_buttons;
    logic [1:0]  pad_valid;
    logic        busy;

    psx_poll_scheduler #(
        .ATT_SETUP(ATT_SETUP), .ATT_HOLD(ATT_HOLD),
        .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .poll_tick(poll_tick), .port_en(port_en),
        .eng_start(eng_start), .eng_bytes(eng_bytes), .eng_ready(eng_ready),
        .eng_err(eng_err), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .cmd_byte(cmd_byte), .att_n(att_n), .pad0_buttons(pad0_buttons),
        .pad1_buttons(pad1_buttons), .pad_valid(pad_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode: 0 ready, 1 err, 2 err+ready together, 3 silent (engine never answers)
    typedef struct {
        int              nbytes;
        logic [6:0][7:0] b;
        int              mode;
        int              delay;
    } resp_t;

    typedef struct {
        logic [1:0]  en;
        int          code[6];
        logic [1:0]  ev;
        logic [15:0] eb0;
        logic [15:0] eb1;
        int          ntx;
    } vec_t;

    resp_t resp_q[$];
    int    txn_ports[$];
    int    viol_overlap = 0, viol_idle_att = 0, viol_setup = 0;
    int    viol_hold = 0, viol_pulse = 0, viol_unexp = 0;

    function automatic resp_t mk_resp(input int code);
        resp_t r;
        r.nbytes = 5; r.b = '0; r.mode = 0; r.delay = 2;
        r.b[0] = 8'hFF; r.b[1] = 8'h41; r.b[2] = 8'h5A; r.b[3] = 8'hFE; r.b[4] = 8'hFF;
        case (code)
            1: begin r.b[3] = 8'h00; r.b[4] = 8'hF0; end
            2: begin r.b[1] = 8'h73; r.b[3] = 8'hFF; end
            3: begin r.nbytes = 4; r.b[3] = 8'hFF; end
            4: r.mode = 1;
            5: r.mode = 2;
            6: begin r.nbytes = 7; r.b[3] = 8'h12; r.b[4] = 8'h34; r.b[5] = 8'hAA; r.b[6] = 8'hBB; end
            7: r.mode = 3;
            default: ;
        endcase
        return r;
    endfunction

    function automatic resp_t mk_rand();
        resp_t r;
        int    sel;
        r = mk_resp(0);
        r.b[3] = 8'($urandom); r.b[4] = 8'($urandom);
        r.delay = $urandom_range(0, 5);
        sel = $urandom_range(0, 9);
        case (sel)
            0: r.mode = 1;
            1: r.mode = 2;
            2: r.b[1] = 8'h41 ^ 8'($urandom_range(1, 255));
            3: r.b[2] = 8'h5A ^ 8'($urandom_range(1, 255));
            4: r.nbytes = $urandom_range(0, 4);
            5: begin r.nbytes = $urandom_range(6, 7); r.b[5] = 8'($urandom); r.b[6] = 8'($urandom); end
            default: ;
        endcase
        return r;
    endfunction

    function automatic vec_t mkv(input logic [1:0] en, input int c0, input int c1, input int c2,
                                 input int c3, input int c4, input int c5, input logic [1:0] ev,
                                 input logic [15:0] b0, input logic [15:0] b1, input int ntx);
        vec_t v;
        v.en = en; v.ev = ev; v.eb0 = b0; v.eb1 = b1; v.ntx = ntx;
        v.code[0] = c0; v.code[1] = c1; v.code[2] = c2;
        v.code[3] = c3; v.code[4] = c4; v.code[5] = c5;
        return v;
    endfunction

    function automatic logic [7:0] exp_cmd(input int idx);
        if (idx == 0) return 8'h01;
        if (idx == 1) return 8'h42;
        return 8'h00;
    endfunction

    // Reference: a poll succeeds iff the engine reports done with >=5 bytes and a valid ID
    logic [1:0]  m_valid = 2'b00;
    logic [15:0] m_b0 = 16'h0, m_b1 = 16'h0;
    int          m_ports[$];

    function automatic bit passes(input resp_t r);
        return (r.mode == 0) && (r.nbytes >= 5) && (r.b[1] == 8'h41) && (r.b[2] == 8'h5A);
    endfunction

    task automatic model_round(input logic [1:0] en, input resp_t lst[$], output int used);
        used = 0;
        m_ports.delete();
        for (int p = 0; p < 2; p++) begin
            if (en[p]) begin
                bit ok;
                ok = 1'b0;
                for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
                    resp_t r;
                    r = lst[used];
                    used++;
                    m_ports.push_back(p);
                    if (passes(r)) begin
                        ok = 1'b1;
                        if (p == 0) m_b0 = ~{r.b[4], r.b[3]};
                        else        m_b1 = ~{r.b[4], r.b[3]};
                    end
                end
                m_valid[p] = ok;
            end
        end
    endtask

    // Bus-level invariants sampled every cycle
    initial begin
        int   att_run, hold_run;
        logic start_prev;
        att_run = 0; hold_run = 0; start_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (att_n == 2'b00) viol_overlap++;
                if (!busy && att_n != 2'b11) viol_idle_att++;
                if (att_n != 2'b11) begin
                    if (hold_run != 0 && hold_run != ATT_HOLD) viol_hold++;
                    hold_run = 0;
                    att_run++;
                end else begin
                    att_run = 0;
                    hold_run = busy ? hold_run + 1 : 0;
                end
                if (eng_start) begin
                    if (start_prev) viol_pulse++;
                    else begin
                        if (att_run != ATT_SETUP + 1) viol_setup++;
                        txn_ports.push_back(att_n == 2'b10 ? 0 : (att_n == 2'b01 ? 1 : 9));
                    end
                end
                start_prev = eng_start;
            end else begin
                att_run = 0; hold_run = 0; start_prev = 1'b0;
            end
        end
    end

    task automatic respond(input resp_t r);
        @(posedge clk); #1;
        for (int i = 0; i < r.nbytes; i++) begin
            check("cmd_byte", 32'(cmd_byte), 32'(exp_cmd(i)));
            rx_valid = 1'b1; rx_byte = r.b[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        for (int i = 0; i < r.delay; i++) begin
            @(posedge clk); #1;
        end
        case (r.mode)
            0: eng_ready = 1'b1;
            1: eng_err = 1'b1;
            2: begin eng_ready = 1'b1; eng_err = 1'b1; end
            default: ;
        endcase
        @(posedge clk); #1;
        eng_ready = 1'b0; eng_err = 1'b0;
    endtask

    // Scripted engine: each eng_start consumes the next queued response
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst && eng_start) begin
                if (resp_q.size() == 0) begin
                    viol_unexp++;
                    r = mk_resp(7);
                end else begin
                    r = resp_q.pop_front();
                end
                respond(r);
            end
        end
    end

    task automatic pulse_tick();
        @(posedge clk); #1 poll_tick = 1'b1;
        @(posedge clk); #1 poll_tick = 1'b0;
    endtask

    task automatic run_round(input logic [1:0] en, input resp_t lst[$], input bit use_model,
                             input logic [1:0] ev, input logic [15:0] eb0, input logic [15:0] eb1,
                             input int entx);
        int used, k;
        model_round(en, lst, used);
        if (use_model) begin
            ev = m_valid; eb0 = m_b0; eb1 = m_b1; entx = used;
        end
        for (int i = 0; i < used; i++) resp_q.push_back(lst[i]);
        txn_ports.delete();
        port_en = en;
        pulse_tick();
        if (en == 2'b00) begin
            repeat (10) @(negedge clk);
            check("busy_no_port", 32'(busy), 32'd0);
        end else begin
            k = 0;
            while (busy !== 1'b1 && k < 6) begin @(negedge clk); k++; end
            check("busy_rise", 32'(busy), 32'd1);
            k = 0;
            while (busy !== 1'b0 && k < 20000) begin @(negedge clk); k++; end
            check("busy_fall", 32'(busy), 32'd0);
        end
        @(negedge clk);
        check("pad_valid", 32'(pad_valid), 32'(ev));
        check("pad0_buttons", 32'(pad0_buttons), 32'(eb0));
        check("pad1_buttons", 32'(pad1_buttons), 32'(eb1));
        check("txn_count", 32'(txn_ports.size()), 32'(entx));
        check("port_seq_len", 32'(txn_ports.size()), 32'(m_ports.size()));
        for (int i = 0; i < txn_ports.size() && i < m_ports.size(); i++)
            check("port_seq", 32'(txn_ports[i]), 32'(m_ports[i]));
        check("resp_left", 32'(resp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t  tbl[6];
        resp_t lst[$];
        int    used, k, busy_seen, n_before;

        tbl[0] = mkv(2'b11, 0, 0, 0, 0, 0, 0, 2'b11, 16'h0001, 16'h0001, 2);
        tbl[1] = mkv(2'b01, 2, 2, 2, 0, 0, 0, 2'b10, 16'h0001, 16'h0001, 3);
        tbl[2] = mkv(2'b10, 1, 0, 0, 0, 0, 0, 2'b10, 16'h0001, 16'h0FFF, 1);
        tbl[3] = mkv(2'b11, 3, 6, 4, 5, 0, 0, 2'b11, 16'hCBED, 16'h0001, 5);
        tbl[4] = mkv(2'b11, 7, 7, 7, 1, 0, 0, 2'b10, 16'hCBED, 16'h0FFF, 4);
        tbl[5] = mkv(2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 16'hCBED, 16'h0FFF, 0);

        repeat (3) @(negedge clk);
        check("rst_att_n", 32'(att_n), 32'h3);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pad_valid", 32'(pad_valid), 32'd0);
        check("rst_pad0", 32'(pad0_buttons), 32'd0);
        check("rst_pad1", 32'(pad1_buttons), 32'd0);
        check("rst_cmd_byte", 32'(cmd_byte), 32'h01);
        check("eng_bytes", 32'(eng_bytes), 32'd5);
        @(posedge clk); #1 rst = 1'b1;
        port_en = 2'b11;
        repeat (20) @(negedge clk);
        check("idle_without_tick", 32'(busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            lst.delete();
            for (int i = 0; i < 6; i++) lst.push_back(mk_resp(tbl[v].code[i]));
            run_round(tbl[v].en, lst, 1'b0, tbl[v].ev, tbl[v].eb0, tbl[v].eb1, tbl[v].ntx);
        end

        // Three ticks inside one busy round collapse into one extra round
        lst.delete(); lst.push_back(mk_resp(0));
        model_round(2'b01, lst, used);
        resp_q.push_back(lst[0]);
        lst.delete(); lst.push_back(mk_resp(1));
        model_round(2'b01, lst, used);
        resp_q.push_back(lst[0]);
        txn_ports.delete();
        port_en = 2'b01;
        pulse_tick();
        k = 0;
        while (busy !== 1'b1 && k < 6) begin @(negedge clk); k++; end
        check("multi_busy_rise", 32'(busy), 32'd1);
        for (int t = 0; t < 3; t++) begin
            repeat (12) @(negedge clk);
            pulse_tick();
        end
        repeat (700) @(negedge clk);
        check("multi_busy_end", 32'(busy), 32'd0);
        check("multi_txn_count", 32'(txn_ports.size()), 32'd2);
        check("multi_pad0", 32'(pad0_buttons), 32'(m_b0));
        check("multi_valid", 32'(pad_valid), 32'(m_valid));

        for (int rnd = 0; rnd < 16; rnd++) begin
            lst.delete();
            for (int i = 0; i < 6; i++) lst.push_back(mk_rand());
            run_round(2'($urandom_range(0, 3)), lst, 1'b1, 2'b00, 16'h0, 16'h0, 0);
        end

        // Reset during port 1 WAIT with a tick already pending
        resp_q.push_back(mk_resp(0));
        resp_q.push_back(mk_resp(7));
        txn_ports.delete();
        port_en = 2'b11;
        pulse_tick();
        k = 0;
        while (txn_ports.size() < 2 && k < 2000) begin @(negedge clk); k++; end
        check("rst_reach_port1", 32'(txn_ports.size()), 32'd2);
        repeat (20) @(negedge clk);
        pulse_tick();
        @(negedge clk); #2 rst = 1'b0;
        #1;
        check("abort_att_n", 32'(att_n), 32'h3);
        check("abort_pad_valid", 32'(pad_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_eng_start", 32'(eng_start), 32'd0);
        check("abort_pad1", 32'(pad1_buttons), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        m_valid = 2'b00; m_b0 = 16'h0; m_b1 = 16'h0;
        resp_q.delete();
        n_before = txn_ports.size();
        busy_seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("post_rst_quiet_busy", 32'(busy_seen), 32'd0);
        check("post_rst_no_start", 32'(txn_ports.size()), 32'(n_before));

        lst.delete();
        lst.push_back(mk_resp(1)); lst.push_back(mk_resp(2)); lst.push_back(mk_resp(0));
        for (int i = 0; i < 3; i++) lst.push_back(mk_resp(0));
        run_round(2'b11, lst, 1'b1, 2'b00, 16'h0, 16'h0, 0);

        check("att_overlap", 32'(viol_overlap), 32'd0);
        check("att_low_when_idle", 32'(viol_idle_att), 32'd0);
        check("att_setup_len", 32'(viol_setup), 32'd0);
        check("att_hold_len", 32'(viol_hold), 32'd0);
        check("start_pulse_width", 32'(viol_pulse), 32'd0);
        check("unexpected_txn", 32'(viol_unexp), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
